core_dmem_bridge: RTL and testbench
===================================

CORE_DMEM_BRIDGE -- requirements
Module: core_dmem_bridge

Interface
REQ-001 Parameter NC_REGIONS, default 2: number of non-cacheable address windows, legal range 1..4.
REQ-002 Parameter NC_BASE, default {32'h0001_0000, 32'h0000_0000}: packed NC_REGIONS x 32-bit window bases; region i occupies bits [32*i+31:32*i].
REQ-003 Parameter NC_OFFSET, default {32'h0000_0fff, 32'h0000_ffff}: packed NC_REGIONS x 32-bit window offset masks, same packing as NC_BASE.
REQ-004 Parameter TIMEOUT, default 255: maximum cycles spent waiting for d_req_ack; legal range 1..65535.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 dmem_en  input  1  pipeline data access request, held until the access completes.
REQ-008 dmem_wen  input  1  1 = store, 0 = load.
REQ-009 dmem_size  input  3  access type: [1:0] 0 byte, 1 half, 2 word, 3 illegal; [2] unsigned flag, passed through unchanged.
REQ-010 dmem_addr  input  32  byte address.
REQ-011 dmem_wdata_delayed  input  32  store data, valid one cycle after the request cycle.
REQ-012 dmem_wait  output  1  stall to the pipeline.
REQ-013 dmem_rdata  output  32  load data.
REQ-014 dmem_badmem_e  output  1  one-cycle access-fault pulse.
REQ-015 d_req_val  output  1  bus request valid.
REQ-016 d_req_addr  output  32  bus address.
REQ-017 d_req_cop  output  3  {1'b0, nc, wr}.
REQ-018 d_req_wdata  output  32  bus store data.
REQ-019 d_req_size  output  3  copy of the captured dmem_size.
REQ-020 d_req_ack  input  1  bus completes the request this cycle.
REQ-021 d_ack_rdata  input  32  load data, valid while d_req_ack = 1.
REQ-022 err_cnt  output  8  saturating fault counter.

Function
REQ-023 The FSM shall have states IDLE, WDATA, REQ and ERR.
REQ-024 IDLE with dmem_en = 1: capture addr, size, wen and nc.
  - Misaligned (half with addr[0] = 1; word with addr[1:0] != 0) or size[1:0] = 3: go to ERR.
  - Otherwise, store: go to WDATA.
  - Otherwise, load: go to REQ.
REQ-025 WDATA shall capture dmem_wdata_delayed into the wdata register and go to REQ after exactly one cycle.
REQ-026 REQ transitions:
  - d_req_val = 1 with captured addr, size, cop and wdata held stable.
  - On d_req_ack = 1: go to IDLE.
  - On timeout: go to ERR.
REQ-027 Timeout counter behaviour:
  - Width = clog2(TIMEOUT + 1).
  - Cleared on entry to REQ and incremented each REQ cycle without ack.
  - When the count equals TIMEOUT and ack = 0: go to ERR and drop d_req_val the next cycle.
  - Ack in that same cycle takes priority: normal completion, no fault.
REQ-028 ERR shall last exactly one cycle, drive dmem_badmem_e = 1 and dmem_wait = 0, then return to IDLE.
REQ-029 dmem_wait shall equal (IDLE & dmem_en) | WDATA | (REQ & ~d_req_ack).
REQ-030 dmem_rdata shall equal d_ack_rdata when REQ & d_req_ack, and otherwise hold the last completed load value.
REQ-031 nc shall be 1 when, for any region i, (dmem_addr & ~NC_OFFSET[i]) == NC_BASE[i].
REQ-032 d_req_cop[0] shall equal the captured wen; d_req_cop[2] shall be 0.
REQ-033 err_cnt shall increment on every ERR entry and saturate at 255.
REQ-034 Back-to-back accesses: in the cycle after a completion, IDLE shall accept a new dmem_en with no idle bubble.
REQ-035 d_req_val shall be 0 in all states other than REQ.

Reset
REQ-036 rst_n = 0 shall asynchronously force all of the following:
  - FSM to IDLE, timeout counter to 0, err_cnt to 0.
  - Captured registers and dmem_rdata to 0.
  - d_req_val = 0, dmem_badmem_e = 0.
REQ-037 Reset asserted mid-REQ shall drop d_req_val immediately; a d_req_ack arriving after reset release while in IDLE shall be ignored.
REQ-038 The first request shall be accepted in the first rising edge after rst_n deassertion.

Verification
REQ-039 Word load at 0x2000_0004, ack after 3 cycles with rdata 0xDEADBEEF -> d_req_val high 3 cycles, cop = 3'b000, dmem_rdata = 0xDEADBEEF, dmem_wait low in the ack cycle.
REQ-040 Byte store at 0x0000_0010 with wdata 0x5A, immediate ack -> WDATA for 1 cycle, then d_req_val with cop = 3'b011 (region 0 nc) and d_req_wdata = 0x5A.
REQ-041 Half load at 0x0001_0FFF (misaligned) -> no d_req_val, badmem pulse in cycle 2, err_cnt = 1.
REQ-042 Word load at 0x0001_0800 with TIMEOUT = 4 and no ack -> d_req_val for 4 cycles, cop = 3'b010, then badmem pulse, err_cnt increments; ack in the 4th cycle -> normal completion.
REQ-043 rst_n pulled low during REQ -> d_req_val = 0 asynchronously; 256 faults -> err_cnt holds 255.
REQ-044 Load followed by store on consecutive cycles, both acked immediately -> second request accepted in the cycle after the first completion.

Source files
------------

// File: rtl/core_dmem_bridge.sv
// Data-memory bridge between the core pipeline and the bus.
// Handles alignment faults, non-cacheable tagging and bus timeout.
module core_dmem_bridge #(
   parameter int                          NC_REGIONS = 2,
   parameter logic [32*NC_REGIONS-1:0]    NC_BASE    = {32'h0001_0000, 32'h0000_0000},
   parameter logic [32*NC_REGIONS-1:0]    NC_OFFSET  = {32'h0000_0fff, 32'h0000_ffff},
   parameter int                          TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dmem_en,
   input  logic        dmem_wen,
   input  logic [2:0]  dmem_size,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_wdata_delayed,
   output logic        dmem_wait,
   output logic [31:0] dmem_rdata,
   output logic        dmem_badmem_e,
   output logic        d_req_val,
   output logic [31:0] d_req_addr,
   output logic [2:0]  d_req_cop,
   output logic [31:0] d_req_wdata,
   output logic [2:0]  d_req_size,
   input  logic        d_req_ack,
   input  logic [31:0] d_ack_rdata,
   output logic [7:0]  err_cnt
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WDATA,
      S_REQ,
      S_ERR
   } state_t;

   state_t          r_state;
   state_t          w_nxt;
   logic [31:0]     r_addr;
   logic [2:0]      r_size;
   logic            r_wen;
   logic            r_nc;
   logic [31:0]     r_wdata;
   logic [31:0]     r_rdata;
   logic [CW-1:0]   r_tcnt;
   logic [CW-1:0]   w_tcnt_inc;
   logic [7:0]      r_err_cnt;
   logic            w_nc;
   logic            w_misal;
   logic            w_tmo;
   logic            w_wait;
   logic            w_accept;
   logic            w_done;

   assign w_accept   = (r_state == S_IDLE) && dmem_en;
   assign w_done     = (r_state == S_REQ) && d_req_ack;
   assign w_tcnt_inc = r_tcnt + 1'b1;
   assign w_tmo      = (w_tcnt_inc == CW'(TIMEOUT));

   // Non-cacheable window match on the incoming address
   always_comb begin
      w_nc = 1'b0;
      for (int i = 0; i < NC_REGIONS; i++) begin
         if ((dmem_addr & ~NC_OFFSET[32*i +: 32]) == NC_BASE[32*i +: 32])
            w_nc = 1'b1;
      end
   end

   // Alignment / illegal-size detection
   always_comb begin
      w_misal = 1'b0;
      case (dmem_size[1:0])
         2'd0:    w_misal = 1'b0;
         2'd1:    w_misal = dmem_addr[0];
         2'd2:    w_misal = |dmem_addr[1:0];
         default: w_misal = 1'b1;
      endcase
   end

   // Next-state and stall decode
   always_comb begin
      w_nxt  = r_state;
      w_wait = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (dmem_en) begin
               w_wait = 1'b1;
               if (w_misal)       w_nxt = S_ERR;
               else if (dmem_wen) w_nxt = S_WDATA;
               else               w_nxt = S_REQ;
            end
         end
         S_WDATA: begin
            w_wait = 1'b1;
            w_nxt  = S_REQ;
         end
         S_REQ: begin
            if (d_req_ack) begin
               w_nxt = S_IDLE;
            end else begin
               w_wait = 1'b1;
               if (w_tmo) w_nxt = S_ERR;
            end
         end
         S_ERR:   w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_nxt;
   end

   // Request capture and delayed store data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr  <= '0;
         r_size  <= '0;
         r_wen   <= 1'b0;
         r_nc    <= 1'b0;
         r_wdata <= '0;
      end else begin
         if (w_accept) begin
            r_addr <= dmem_addr;
            r_size <= dmem_size;
            r_wen  <= dmem_wen;
            r_nc   <= w_nc;
         end
         if (r_state == S_WDATA)
            r_wdata <= dmem_wdata_delayed;
      end
   end

   // Bus timeout counter, zero outside REQ
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                               r_tcnt <= '0;
      else if (r_state == S_REQ && !d_req_ack)  r_tcnt <= w_tcnt_inc;
      else                                      r_tcnt <= '0;
   end

   // Last completed load value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                r_rdata <= '0;
      else if (w_done && !r_wen) r_rdata <= d_ack_rdata;
   end

   // Saturating fault counter, bumped on ERR entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_err_cnt <= '0;
      else if (w_nxt == S_ERR && r_state != S_ERR && r_err_cnt != 8'hFF)
         r_err_cnt <= r_err_cnt + 8'd1;
   end

   assign dmem_wait     = w_wait;
   assign dmem_rdata    = w_done ? d_ack_rdata : r_rdata;
   assign dmem_badmem_e = (r_state == S_ERR);
   assign d_req_val     = (r_state == S_REQ);
   assign d_req_addr    = r_addr;
   assign d_req_cop     = {1'b0, r_nc, r_wen};
   assign d_req_wdata   = r_wdata;
   assign d_req_size    = r_size;
   assign err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_core_dmem_bridge.sv
// Directed bench for core_dmem_bridge with TIMEOUT = 4.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_core_dmem_bridge;

   logic        clk;
   logic        rst_n;
   logic        dmem_en;
   logic        dmem_wen;
   logic [2:0]  dmem_size;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata_delayed;
   logic        dmem_wait;
   logic [31:0] dmem_rdata;
   logic        dmem_badmem_e;
   logic        d_req_val;
   logic [31:0] d_req_addr;
   logic [2:0]  d_req_cop;
   logic [31:0] d_req_wdata;
   logic [2:0]  d_req_size;
   logic        d_req_ack;
   logic [31:0] d_ack_rdata;
   logic [7:0]  err_cnt;

   int errors = 0;
   int checks = 0;

   core_dmem_bridge #(.TIMEOUT(4)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .dmem_en            (dmem_en),
      .dmem_wen           (dmem_wen),
      .dmem_size          (dmem_size),
      .dmem_addr          (dmem_addr),
      .dmem_wdata_delayed (dmem_wdata_delayed),
      .dmem_wait          (dmem_wait),
      .dmem_rdata         (dmem_rdata),
      .dmem_badmem_e      (dmem_badmem_e),
      .d_req_val          (d_req_val),
      .d_req_addr         (d_req_addr),
      .d_req_cop          (d_req_cop),
      .d_req_wdata        (d_req_wdata),
      .d_req_size         (d_req_size),
      .d_req_ack          (d_req_ack),
      .d_ack_rdata        (d_ack_rdata),
      .err_cnt            (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic en, input logic wen, input logic [2:0] sz, input logic [31:0] a);
      dmem_en   = en;
      dmem_wen  = wen;
      dmem_size = sz;
      dmem_addr = a;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 3'd0, 32'h0);
      dmem_wdata_delayed = 32'h0;
      d_req_ack   = 1'b0;
      d_ack_rdata = 32'h0;

      // reset state
      #3;
      chk("rst_val",    32'(d_req_val),     32'h0);
      chk("rst_bad",    32'(dmem_badmem_e), 32'h0);
      chk("rst_errcnt", 32'(err_cnt),       32'h0);
      chk("rst_rdata",  dmem_rdata,         32'h0);
      chk("rst_wait",   32'(dmem_wait),     32'h0);
      repeat (2) @(posedge clk);
      #1;

      // word load 0x2000_0004, ack on third REQ cycle
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 3'b010, 32'h2000_0004);
      #1;
      chk("ld_idle_wait", 32'(dmem_wait), 32'h1);
      chk("ld_idle_val",  32'(d_req_val), 32'h0);
      tick();
      chk("ld_r1_val",  32'(d_req_val),  32'h1);
      chk("ld_r1_cop",  32'(d_req_cop),  32'h0);
      chk("ld_r1_addr", d_req_addr,      32'h2000_0004);
      chk("ld_r1_size", 32'(d_req_size), 32'h2);
      chk("ld_r1_wait", 32'(dmem_wait),  32'h1);
      tick();
      chk("ld_r2_val",  32'(d_req_val),  32'h1);
      tick();
      d_req_ack   = 1'b1;
      d_ack_rdata = 32'hDEAD_BEEF;
      #1;
      chk("ld_r3_val",   32'(d_req_val), 32'h1);
      chk("ld_r3_wait",  32'(dmem_wait), 32'h0);
      chk("ld_r3_rdata", dmem_rdata,     32'hDEAD_BEEF);
      tick();
      dmem_en = 1'b0; d_req_ack = 1'b0; d_ack_rdata = 32'h0;
      #1;
      chk("ld_done_val",   32'(d_req_val), 32'h0);
      chk("ld_hold_rdata", dmem_rdata,     32'hDEAD_BEEF);

      // byte store 0x10, wdata 0x5A, immediate ack
      tick();
      drive(1'b1, 1'b1, 3'b000, 32'h0000_0010);
      #1;
      chk("st_idle_wait", 32'(dmem_wait), 32'h1);
      tick();
      dmem_wdata_delayed = 32'h0000_005A;
      #1;
      chk("st_wd_val",  32'(d_req_val), 32'h0);
      chk("st_wd_wait", 32'(dmem_wait), 32'h1);
      tick();
      dmem_wdata_delayed = 32'h0;
      d_req_ack   = 1'b1;
      d_ack_rdata = 32'hCAFE_0000;
      #1;
      chk("st_val",   32'(d_req_val),  32'h1);
      chk("st_cop",   32'(d_req_cop),  32'h3);
      chk("st_wdata", d_req_wdata,     32'h0000_005A);
      chk("st_size",  32'(d_req_size), 32'h0);
      chk("st_wait",  32'(dmem_wait),  32'h0);
      tick();
      dmem_en = 1'b0; d_req_ack = 1'b0; d_ack_rdata = 32'h0;
      #1;
      chk("st_done_val", 32'(d_req_val), 32'h0);
      chk("st_rdata",    dmem_rdata,     32'hDEAD_BEEF);

      // misaligned half load 0x0001_0FFF
      tick();
      drive(1'b1, 1'b0, 3'b001, 32'h0001_0FFF);
      #1;
      chk("mis_c1_wait", 32'(dmem_wait),     32'h1);
      chk("mis_c1_bad",  32'(dmem_badmem_e), 32'h0);
      tick();
      dmem_en = 1'b0;
      #1;
      chk("mis_c2_bad",  32'(dmem_badmem_e), 32'h1);
      chk("mis_c2_wait", 32'(dmem_wait),     32'h0);
      chk("mis_c2_val",  32'(d_req_val),     32'h0);
      chk("mis_c2_cnt",  32'(err_cnt),       32'h1);
      tick();
      chk("mis_c3_bad",  32'(dmem_badmem_e), 32'h0);
      chk("mis_c3_cnt",  32'(err_cnt),       32'h1);

      // illegal size and misaligned word
      drive(1'b1, 1'b0, 3'b011, 32'h0000_0000);
      tick();
      dmem_en = 1'b0;
      #1;
      chk("ill_bad", 32'(dmem_badmem_e), 32'h1);
      tick();
      drive(1'b1, 1'b1, 3'b010, 32'h0000_0002);
      tick();
      dmem_en = 1'b0;
      #1;
      chk("misw_bad", 32'(dmem_badmem_e), 32'h1);
      chk("misw_val", 32'(d_req_val),     32'h0);
      tick();
      chk("misw_cnt", 32'(err_cnt), 32'h3);

      // timeout: word load 0x0001_0800, no ack
      drive(1'b1, 1'b0, 3'b110, 32'h0001_0800);
      tick();
      chk("to_r1_val",  32'(d_req_val),  32'h1);
      chk("to_r1_cop",  32'(d_req_cop),  32'h2);
      chk("to_r1_size", 32'(d_req_size), 32'h6);
      tick();
      chk("to_r2_val", 32'(d_req_val), 32'h1);
      tick();
      chk("to_r3_val", 32'(d_req_val), 32'h1);
      tick();
      chk("to_r4_val",  32'(d_req_val), 32'h1);
      chk("to_r4_wait", 32'(dmem_wait), 32'h1);
      tick();
      dmem_en = 1'b0;
      #1;
      chk("to_err_val", 32'(d_req_val),     32'h0);
      chk("to_err_bad", 32'(dmem_badmem_e), 32'h1);
      chk("to_err_cnt", 32'(err_cnt),       32'h4);
      tick();

      // ack on the last permitted cycle wins
      drive(1'b1, 1'b0, 3'b010, 32'h0001_0800);
      tick();
      tick();
      tick();
      tick();
      d_req_ack   = 1'b1;
      d_ack_rdata = 32'h1234_5678;
      #1;
      chk("late_wait",  32'(dmem_wait), 32'h0);
      chk("late_rdata", dmem_rdata,     32'h1234_5678);
      tick();
      dmem_en = 1'b0; d_req_ack = 1'b0; d_ack_rdata = 32'h0;
      #1;
      chk("late_bad",   32'(dmem_badmem_e), 32'h0);
      chk("late_val",   32'(d_req_val),     32'h0);
      chk("late_cnt",   32'(err_cnt),       32'h4);
      chk("late_hold",  dmem_rdata,         32'h1234_5678);

      // back-to-back load then store
      tick();
      drive(1'b1, 1'b0, 3'b010, 32'h0000_0100);
      tick();
      d_req_ack   = 1'b1;
      d_ack_rdata = 32'hA5A5_A5A5;
      #1;
      chk("b2b_ld_wait", 32'(dmem_wait), 32'h0);
      tick();
      drive(1'b1, 1'b1, 3'b010, 32'h0000_0104);
      d_req_ack = 1'b0; d_ack_rdata = 32'h0;
      #1;
      chk("b2b_idle_val",  32'(d_req_val), 32'h0);
      chk("b2b_idle_wait", 32'(dmem_wait), 32'h1);
      chk("b2b_rdata",     dmem_rdata,     32'hA5A5_A5A5);
      tick();
      dmem_wdata_delayed = 32'h0BAD_F00D;
      #1;
      chk("b2b_wd_val", 32'(d_req_val), 32'h0);
      tick();
      dmem_wdata_delayed = 32'h0;
      d_req_ack = 1'b1;
      #1;
      chk("b2b_st_val",   32'(d_req_val), 32'h1);
      chk("b2b_st_cop",   32'(d_req_cop), 32'h3);
      chk("b2b_st_addr",  d_req_addr,     32'h0000_0104);
      chk("b2b_st_wdata", d_req_wdata,    32'h0BAD_F00D);
      tick();
      dmem_en = 1'b0; d_req_ack = 1'b0;

      // reset during REQ, stray ack afterwards
      tick();
      drive(1'b1, 1'b0, 3'b010, 32'h2000_0000);
      tick();
      chk("rr_val_pre", 32'(d_req_val), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rr_val_async", 32'(d_req_val),  32'h0);
      chk("rr_cnt",       32'(err_cnt),    32'h0);
      chk("rr_rdata",     dmem_rdata,      32'h0);
      chk("rr_addr",      d_req_addr,      32'h0);
      dmem_en = 1'b0;
      #1;
      rst_n = 1'b1;
      tick();
      d_req_ack   = 1'b1;
      d_ack_rdata = 32'hFFFF_FFFF;
      #1;
      chk("rr_stray_val",   32'(d_req_val), 32'h0);
      chk("rr_stray_rdata", dmem_rdata,     32'h0);
      chk("rr_stray_wait",  32'(dmem_wait), 32'h0);
      tick();
      d_req_ack = 1'b0; d_ack_rdata = 32'h0;
      #1;
      chk("rr_after_rdata", dmem_rdata, 32'h0);

      // err_cnt saturation: 260 back-to-back faults
      drive(1'b1, 1'b0, 3'b010, 32'h0000_0001);
      repeat (520) tick();
      dmem_en = 1'b0;
      tick();
      chk("sat_cnt", 32'(err_cnt),       32'hFF);
      chk("sat_bad", 32'(dmem_badmem_e), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
